multicycle_control: RTL and testbench

//  Multi-cycle RV32I control FSM; successor to the single-cycle decoder. Sequences FETCH/DECODE/

---
 rtl/multicycle_control.sv | 197 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Purpose : multi-cycle RV32I control FSM (FETCH/DECODE/EXEC/MEM/WB) over a shared memory port.
// Latency : FETCH..retire with zero memory wait: R/I 4, LOAD 5, STORE 4, BRANCH 3 cycles.
// Backpr. : FETCH/MEM hold their request until mem_ready_i; trap when the wait exceeds MEM_TIMEOUT.
//
// Ports:
//   clk_i, rst_i          clock (rising edge), asynchronous active-high reset
//   Op_i[6:0]             opcode from the instruction register, sampled in DECODE
//   mem_ready_i           memory completes the current access this cycle
//   ALUOp_o, ALUSrc_o     ALU control (EXEC/MEM only)
//   RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o, IRWrite_o, PCWrite_o, Branch_o  datapath enables
//   illegal_o             sticky trap flag
//   state_o[2:0]          current state encoding
//   retired_o             retired instruction count (wraps)
module multicycle_control #(
    parameter int ALUOP_W       = 2,
    parameter int MEM_TIMEOUT   = 15,
    parameter int ENABLE_BRANCH = 1,
    parameter int CNT_W         = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [6:0]         Op_i,
    input  logic               mem_ready_i,
    output logic [ALUOP_W-1:0] ALUOp_o,
    output logic               ALUSrc_o,
    output logic               RegWrite_o,
    output logic               MemRead_o,
    output logic               MemWrite_o,
    output logic               MemtoReg_o,
    output logic               IRWrite_o,
    output logic               PCWrite_o,
    output logic               Branch_o,
    output logic               illegal_o,
    output logic [2:0]         state_o,
    output logic [CNT_W-1:0]   retired_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_TRAP   = 3'd6;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    // Wait counter only needs to reach MEM_TIMEOUT; it saturates so a disabled
    // timeout can never wrap it back into a spurious match.
    localparam int              WAIT_W   = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_TMO = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

    logic [2:0]        state_q, state_d;
    logic [6:0]        op_q, op_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  retired_q, retired_d;

    logic op_legal, timed_out, retire;
    logic is_ld, is_st, is_br, is_i;
    logic [1:0] aluop;

    always_comb begin
        is_ld = (op_q == OP_LD);
        is_st = (op_q == OP_ST);
        is_br = (op_q == OP_BR);
        is_i  = (op_q == OP_I);
        op_legal = (Op_i == OP_R) || (Op_i == OP_I) || (Op_i == OP_LD) || (Op_i == OP_ST) ||
                   ((ENABLE_BRANCH != 0) && (Op_i == OP_BR));
        // A ready on the final permitted cycle still completes the access.
        timed_out = (MEM_TIMEOUT != 0) && (wait_q == WAIT_TMO) && !mem_ready_i;
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        retire  = 1'b0;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready_i)    state_d = S_DECODE;
                else if (timed_out) state_d = S_TRAP;
            end
            S_DECODE: begin
                op_d    = Op_i;
                state_d = op_legal ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                if (is_ld || is_st) begin
                    state_d = S_MEM;
                end else if (is_br) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (mem_ready_i) begin
                    if (is_st) begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timed_out) begin
                    state_d = S_TRAP;
                end
            end
            S_WB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_IDLE;
        endcase

        // Any state change is an entry into a fresh wait window; only FETCH/MEM
        // can stall in place, so only they accumulate.
        wait_d = wait_q;
        if (state_d != state_q) begin
            wait_d = '0;
        end else if (((state_q == S_FETCH) || (state_q == S_MEM)) && (wait_q != WAIT_MAX)) begin
            wait_d = wait_q + 1'b1;
        end

        retired_d = retire ? (retired_q + 1'b1) : retired_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            wait_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
        end
    end

    // Outputs are Moore on state/op, except IRWrite/PCWrite which follow ready in FETCH.
    always_comb begin
        aluop      = 2'b00;
        ALUSrc_o   = 1'b0;
        RegWrite_o = 1'b0;
        MemRead_o  = 1'b0;
        MemWrite_o = 1'b0;
        MemtoReg_o = 1'b0;
        IRWrite_o  = 1'b0;
        PCWrite_o  = 1'b0;
        Branch_o   = 1'b0;
        if ((state_q == S_EXEC) || (state_q == S_MEM)) begin
            if (is_ld || is_st) begin
                aluop    = 2'b00;
                ALUSrc_o = 1'b1;
            end else if (is_br) begin
                aluop    = 2'b01;
            end else if (is_i) begin
                aluop    = 2'b11;
                ALUSrc_o = 1'b1;
            end else begin
                aluop    = 2'b10;
            end
        end
        case (state_q)
            S_FETCH: begin
                MemRead_o = 1'b1;
                IRWrite_o = mem_ready_i;
                PCWrite_o = mem_ready_i;
            end
            S_EXEC:  Branch_o = is_br;
            S_MEM: begin
                MemRead_o  = is_ld;
                MemWrite_o = is_st;
            end
            S_WB: begin
                RegWrite_o = 1'b1;
                MemtoReg_o = is_ld;
            end
            default: ;
        endcase
        ALUOp_o      = '0;
        ALUOp_o[1:0] = aluop;
    end

    assign illegal_o = (state_q == S_TRAP);
    assign state_o   = state_q;
    assign retired_o = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Purpose : self-checking bench for multicycle_control; per-cycle model compare plus directed literals.
// Latency : n/a (bench).
// Backpr. : memory ready is driven per cycle from directed stimulus.
module tb_multicycle_control;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_EXEC = 3, S_MEM = 4, S_WB = 5, S_TRAP = 6;
    localparam int C_NONE = 0, C_R = 1, C_I = 2, C_LD = 3, C_ST = 4, C_BR = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Instance 0: default parameters.
    logic        rst0, rdy0;
    logic [6:0]  op0;
    logic [1:0]  alu0;
    logic        src0, rw0, mr0, mw0, m2r0, irw0, pcw0, br0, ill0;
    logic [2:0]  st0;
    logic [31:0] ret0;
    logic [14:0] act0;

    // Instance 1: short timeout, branch disabled, 4-bit counter, wide ALUOp.
    logic        rst1, rdy1;
    logic [6:0]  op1;
    logic [2:0]  alu1;
    logic        src1, rw1, mr1, mw1, m2r1, irw1, pcw1, br1, ill1;
    logic [2:0]  st1;
    logic [3:0]  ret1;
    logic [14:0] act1;

    multicycle_control dut0 (
        .clk_i(clk), .rst_i(rst0), .Op_i(op0), .mem_ready_i(rdy0),
        .ALUOp_o(alu0), .ALUSrc_o(src0), .RegWrite_o(rw0), .MemRead_o(mr0), .MemWrite_o(mw0),
        .MemtoReg_o(m2r0), .IRWrite_o(irw0), .PCWrite_o(pcw0), .Branch_o(br0),
        .illegal_o(ill0), .state_o(st0), .retired_o(ret0)
    );

    multicycle_control #(.ALUOP_W(3), .MEM_TIMEOUT(3), .ENABLE_BRANCH(0), .CNT_W(4)) dut1 (
        .clk_i(clk), .rst_i(rst1), .Op_i(op1), .mem_ready_i(rdy1),
        .ALUOp_o(alu1), .ALUSrc_o(src1), .RegWrite_o(rw1), .MemRead_o(mr1), .MemWrite_o(mw1),
        .MemtoReg_o(m2r1), .IRWrite_o(irw1), .PCWrite_o(pcw1), .Branch_o(br1),
        .illegal_o(ill1), .state_o(st1), .retired_o(ret1)
    );

    assign act0 = {1'b0, alu0, src0, rw0, mr0, mw0, m2r0, irw0, pcw0, br0, ill0, st0};
    assign act1 = {alu1, src1, rw1, mr1, mw1, m2r1, irw1, pcw1, br1, ill1, st1};

    // ---------------- behavioural model ----------------
    typedef struct {
        int     st;
        int     cls;
        int     waited;
        longint retired;
    } mdl_t;

    function automatic mdl_t mreset();
        mdl_t r;
        r.st = S_IDLE; r.cls = C_NONE; r.waited = 0; r.retired = 0;
        return r;
    endfunction

    function automatic int classify(logic [6:0] op, bit en_br);
        if (op == OP_R)  return C_R;
        if (op == OP_I)  return C_I;
        if (op == OP_LD) return C_LD;
        if (op == OP_ST) return C_ST;
        if (op == OP_BR && en_br) return C_BR;
        return C_NONE;
    endfunction

    // Phases an instruction visits after DECODE; -1 means it retires from here.
    function automatic int next_after(int cls, int st);
        int p [3];
        int n;
        p[0] = S_EXEC; p[1] = -1; p[2] = -1; n = 1;
        case (cls)
            C_R, C_I: begin p[1] = S_WB; n = 2; end
            C_LD:     begin p[1] = S_MEM; p[2] = S_WB; n = 3; end
            C_ST:     begin p[1] = S_MEM; n = 2; end
            default:  n = 1;
        endcase
        for (int i = 0; i < n; i++)
            if (p[i] == st) return (i + 1 < n) ? p[i + 1] : -1;
        return -1;
    endfunction

    function automatic mdl_t step(mdl_t m, logic rdy, logic [6:0] op, int tmo, bit en_br, int cw);
        mdl_t n = m;
        int   nx;
        case (m.st)
            S_IDLE: begin n.st = S_FETCH; n.waited = 0; end
            S_DECODE: begin
                n.cls = classify(op, en_br);
                n.st  = (n.cls == C_NONE) ? S_TRAP : S_EXEC;
            end
            S_FETCH, S_MEM, S_EXEC, S_WB: begin
                if ((m.st == S_FETCH || m.st == S_MEM) && !rdy) begin
                    if (tmo != 0 && m.waited == tmo) n.st = S_TRAP;
                    else n.waited = m.waited + 1;
                end else begin
                    nx = (m.st == S_FETCH) ? S_DECODE : next_after(m.cls, m.st);
                    if (nx < 0) begin
                        n.st = S_FETCH;
                        n.retired = (m.retired + 1) & ((longint'(1) << cw) - 1);
                    end else begin
                        n.st = nx;
                    end
                    n.waited = 0;
                end
            end
            default: ;
        endcase
        return n;
    endfunction

    function automatic logic [14:0] exp_out(mdl_t m, logic rdy);
        logic [2:0] alu;
        logic src, rw, mr, mw, m2r, irw, br, ill;
        alu = 3'b000; src = 1'b0;
        if (m.st == S_EXEC || m.st == S_MEM) begin
            case (m.cls)
                C_R:       alu = 3'b010;
                C_I:       begin alu = 3'b011; src = 1'b1; end
                C_LD, C_ST: src = 1'b1;
                C_BR:      alu = 3'b001;
                default:   ;
            endcase
        end
        rw  = (m.st == S_WB);
        m2r = (m.st == S_WB) && (m.cls == C_LD);
        mr  = (m.st == S_FETCH) || ((m.st == S_MEM) && (m.cls == C_LD));
        mw  = (m.st == S_MEM) && (m.cls == C_ST);
        irw = (m.st == S_FETCH) && rdy;
        br  = (m.st == S_EXEC) && (m.cls == C_BR);
        ill = (m.st == S_TRAP);
        return {alu, src, rw, mr, mw, m2r, irw, irw, br, ill, 3'(m.st)};
    endfunction

    task automatic cmp(input string nm, input logic [14:0] a, input logic [14:0] e,
                       input longint ra, input longint re);
        n_tests++;
        if (a !== e || ra != re) begin
            n_fail++;
            $display("FAIL %s t=%0t outs act=%b exp=%b retired act=%0d exp=%0d", nm, $time, a, e, ra, re);
        end
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s t=%0t act=%0d exp=%0d", nm, $time, act, exp);
        end
    endtask

    mdl_t m0, m1;

    initial begin
        m0 = mreset();
        m1 = mreset();
        forever begin
            @(negedge clk);
            if (rst0) m0 = mreset();
            if (rst1) m1 = mreset();
            cmp("model_d0", act0, exp_out(m0, rdy0), longint'(ret0), m0.retired);
            cmp("model_d1", act1, exp_out(m1, rdy1), longint'(ret1), m1.retired);
            @(posedge clk);
            m0 = rst0 ? mreset() : step(m0, rdy0, op0, 15, 1'b1, 32);
            m1 = rst1 ? mreset() : step(m1, rdy1, op1, 3, 1'b0, 4);
        end
    end

    // ---------------- directed stimulus ----------------
    // Runs one instruction on dut0 starting in FETCH; MEM waits mem_wait cycles before ready.
    task automatic run0(input logic [6:0] op, input int mem_wait, output int lat,
                        output int n_rd, output int n_wr, output int n_rw, output int n_br,
                        output int n_m2r, output logic [2:0] exec_ctl);
        logic [31:0] start;
        int memw;
        start = ret0; memw = 0; lat = 0;
        n_rd = 0; n_wr = 0; n_rw = 0; n_br = 0; n_m2r = 0; exec_ctl = 3'b000;
        while (ret0 == start && lat < 20) begin
            op0  = op;
            rdy0 = !(st0 == 3'd4 && memw < mem_wait);
            if (st0 == 3'd4 && !rdy0) memw++;
            #1;
            if (st0 == 3'd4 && mr0) n_rd++;
            n_wr  += int'(mw0);
            n_rw  += int'(rw0);
            n_br  += int'(br0);
            n_m2r += int'(m2r0);
            if (st0 == 3'd3) exec_ctl = {alu0, src0};
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat, n_rd, n_wr, n_rw, n_br, n_m2r;
        logic [2:0] ctl;
        rst0 = 1'b1; rst1 = 1'b1; rdy0 = 1'b0; rdy1 = 1'b0; op0 = '0; op1 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs0", longint'(act0), 0);
        chk("reset_ret0", longint'(ret0), 0);
        rst0 = 1'b0;
        #1 chk("idle_state0", longint'(st0), 0);
        @(posedge clk); #1;
        chk("fetch_after_idle0", longint'(st0), 1);

        // R-type, zero wait
        run0(OP_R, 0, lat, n_rd, n_wr, n_rw, n_br, n_m2r, ctl);
        chk("r_latency", lat, 4);
        chk("r_exec_ctl", longint'(ctl), 3'b100);
        chk("r_regwrite_cycles", n_rw, 1);
        chk("r_retired", longint'(ret0), 1);

        // LOAD with 3 wait cycles in MEM
        run0(OP_LD, 3, lat, n_rd, n_wr, n_rw, n_br, n_m2r, ctl);
        chk("ld_latency", lat, 8);
        chk("ld_memread_cycles", n_rd, 4);
        chk("ld_memtoreg", n_m2r, 1);
        chk("ld_exec_ctl", longint'(ctl), 3'b001);

        // STORE then BRANCH
        run0(OP_ST, 0, lat, n_rd, n_wr, n_rw, n_br, n_m2r, ctl);
        chk("st_latency", lat, 4);
        chk("st_memwrite_cycles", n_wr, 1);
        chk("st_no_regwrite", n_rw, 0);
        run0(OP_BR, 0, lat, n_rd, n_wr, n_rw, n_br, n_m2r, ctl);
        chk("br_latency", lat, 3);
        chk("br_branch_cycles", n_br, 1);
        chk("br_exec_ctl", longint'(ctl), 3'b010);
        chk("st_br_retired", longint'(ret0), 4);

        // I-type
        run0(OP_I, 0, lat, n_rd, n_wr, n_rw, n_br, n_m2r, ctl);
        chk("i_exec_ctl", longint'(ctl), 3'b111);
        chk("i_latency", lat, 4);

        // Async reset in the middle of a stalled load
        op0 = OP_LD; rdy0 = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rdy0 = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_state", longint'(st0), 4);
        chk("pre_rst_memread", longint'(mr0), 1);
        rst0 = 1'b1;
        #1;
        chk("mid_rst_outs", longint'(act0), 0);
        chk("mid_rst_ret", longint'(ret0), 0);
        @(posedge clk); #1;
        rst0 = 1'b0;
        #1 chk("post_rst_idle", longint'(st0), 0);
        @(posedge clk); #1;
        chk("post_rst_fetch", longint'(st0), 1);

        // Illegal opcode -> sticky trap, ready ignored
        op0 = OP_BAD; rdy0 = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("trap_state", longint'(st0), 6);
        chk("trap_illegal", longint'(ill0), 1);
        repeat (3) @(posedge clk);
        #1;
        chk("trap_held", longint'(st0), 6);
        chk("trap_no_irwrite", longint'(irw0), 0);
        rst0 = 1'b1;

        // ---- instance 1: FETCH timeout ----
        @(posedge clk); #1;
        rst1 = 1'b0; rdy1 = 1'b0; op1 = OP_R;
        @(posedge clk); #1;
        chk("t_fetch", longint'(st1), 1);
        repeat (3) @(posedge clk);
        #1;
        chk("t_fetch_wait3", longint'(st1), 1);
        @(posedge clk); #1;
        chk("t_fetch_timeout", longint'(st1), 6);

        // Ready on the final allowed cycle wins; disabled branch opcode traps
        rst1 = 1'b1;
        @(posedge clk); #1;
        rst1 = 1'b0;
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;
        rdy1 = 1'b1; op1 = OP_BR;
        @(posedge clk); #1;
        chk("t_ready_last_cycle", longint'(st1), 2);
        @(posedge clk); #1;
        chk("t_branch_disabled", longint'(st1), 6);
        chk("t_branch_illegal", longint'(ill1), 1);

        // MEM timeout on a load: trap, no retire
        rst1 = 1'b1;
        @(posedge clk); #1;
        rst1 = 1'b0; rdy1 = 1'b1; op1 = OP_LD;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rdy1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t_mem_wait3", longint'(st1), 4);
        @(posedge clk); #1;
        chk("t_mem_timeout", longint'(st1), 6);
        chk("t_mem_no_retire", longint'(ret1), 0);

        // 16 R-type instructions wrap a 4-bit counter
        rst1 = 1'b1;
        @(posedge clk); #1;
        rst1 = 1'b0; rdy1 = 1'b1; op1 = OP_R;
        @(posedge clk); #1;
        repeat (15 * 4) @(posedge clk);
        #1;
        chk("wrap_at_15", longint'(ret1), 15);
        chk("wrap_fetch", longint'(st1), 1);
        repeat (4) @(posedge clk);
        #1;
        chk("wrap_to_0", longint'(ret1), 0);

        rst1 = 1'b1;
        @(posedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
